// File: rtl/sprite_fetch_engine.sv
`default_nettype none
//==============================================================================
// Module   : sprite_fetch_engine
// Purpose  : Streams one sprite frame out of banked sprite ROM as screen-
//            addressed pixels through a 2-entry output buffer.
// Options  : define TRANSPARENCY_EN to drop pixels whose colour is TRANS_COLOUR.
// Revision : 1.0 - initial release
//==============================================================================
module sprite_fetch_engine #(
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int FRAMES       = 8,
    parameter int NUM_BANKS    = 4,
    parameter int COL_W        = 3,
    parameter int TRANS_COLOUR = 0
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [$clog2(FRAMES)-1:0]               frame_id,
    input  logic [$clog2(NUM_BANKS)-1:0]            bank_sel,
    input  logic [7:0]                              base_x,
    input  logic [7:0]                              base_y,
    output logic [$clog2(FRAMES*SPR_W*SPR_H)-1:0]   rom_addr,
    input  logic [NUM_BANKS*COL_W-1:0]              rom_q,
    output logic                                    px_valid,
    input  logic                                    px_ready,
    output logic [7:0]                              px_x,
    output logic [7:0]                              px_y,
    output logic [COL_W-1:0]                        px_colour,
    output logic                                    busy,
    output logic                                    done
);

    localparam int c_IW = $clog2(SPR_W);
    localparam int c_JW = $clog2(SPR_H);
    localparam int c_FW = $clog2(FRAMES);
    localparam int c_BW = $clog2(NUM_BANKS);
    localparam logic [c_IW-1:0] c_I_MAX = c_IW'(SPR_W - 1);
    localparam logic [c_JW-1:0] c_J_MAX = c_JW'(SPR_H - 1);

`ifdef TRANSPARENCY_EN
    localparam bit c_TRANS_EN = 1'b1;
`else
    localparam bit c_TRANS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_FW-1:0]     r_frame;
    logic [c_BW-1:0]     r_bank;
    logic [7:0]          r_bx, r_by;
    logic [c_IW-1:0]     r_i, r_rd_i;
    logic [c_JW-1:0]     r_j, r_rd_j;
    logic                r_go;
    logic                r_rdv;
    logic                r_busy, r_done;
    logic                r_hd_vld, r_tl_vld;
    logic [7:0]          r_hd_x, r_hd_y, r_tl_x, r_tl_y;
    logic [COL_W-1:0]    r_hd_c, r_tl_c;

    logic                w_pop, w_push, w_issue, w_last;
    logic [1:0]          w_fill;
    logic [COL_W-1:0]    w_colour;
    logic [7:0]          w_nx, w_ny;

    // Occupancy after this cycle's pop, plus the read whose data is on rom_q now.
    assign w_pop    = r_hd_vld & px_ready;
    assign w_fill   = {1'b0, r_hd_vld} + {1'b0, r_tl_vld} + {1'b0, r_rdv} - {1'b0, w_pop};
    assign w_issue  = (r_state == S_FETCH) && r_go && (w_fill < 2'd2);
    assign w_last   = (r_i == c_I_MAX) && (r_j == c_J_MAX);
    assign w_colour = rom_q[r_bank*COL_W +: COL_W];
    assign w_push   = r_rdv && !(c_TRANS_EN && (w_colour == COL_W'(TRANS_COLOUR)));
    assign w_nx     = r_bx + 8'(r_rd_i);
    assign w_ny     = r_by + 8'(r_rd_j);

    assign rom_addr  = (r_state == S_FETCH) ? {r_frame, r_j, r_i} : '0;
    assign px_valid  = r_hd_vld;
    assign px_x      = r_hd_x;
    assign px_y      = r_hd_y;
    assign px_colour = r_hd_c;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_frame  <= '0;
            r_bank   <= '0;
            r_bx     <= '0;
            r_by     <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_rd_i   <= '0;
            r_rd_j   <= '0;
            r_go     <= 1'b0;
            r_rdv    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hd_vld <= 1'b0;
            r_tl_vld <= 1'b0;
            r_hd_x   <= '0;
            r_hd_y   <= '0;
            r_hd_c   <= '0;
            r_tl_x   <= '0;
            r_tl_y   <= '0;
            r_tl_c   <= '0;
        end else begin
            r_done <= 1'b0;
            r_rdv  <= w_issue;
            r_rd_i <= r_i;
            r_rd_j <= r_j;
            if (w_issue) begin
                r_i <= r_i + c_IW'(1);
                if (r_i == c_I_MAX)
                    r_j <= r_j + c_JW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame <= frame_id;
                        r_bank  <= bank_sel;
                        r_bx    <= base_x;
                        r_by    <= base_y;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_go    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Reads begin one cycle into FETCH so the first pixel lands three cycles after start.
                    r_go <= 1'b1;
                    if (w_issue && w_last)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_fill == 2'd0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Head entry drives the outputs and only changes on pop or when empty.
            if (w_pop) begin
                if (r_tl_vld) begin
                    r_hd_x   <= r_tl_x;
                    r_hd_y   <= r_tl_y;
                    r_hd_c   <= r_tl_c;
                    r_tl_vld <= w_push;
                    if (w_push) begin
                        r_tl_x <= w_nx;
                        r_tl_y <= w_ny;
                        r_tl_c <= w_colour;
                    end
                end else begin
                    r_hd_vld <= w_push;
                    if (w_push) begin
                        r_hd_x <= w_nx;
                        r_hd_y <= w_ny;
                        r_hd_c <= w_colour;
                    end
                end
            end else if (w_push) begin
                if (!r_hd_vld) begin
                    r_hd_vld <= 1'b1;
                    r_hd_x   <= w_nx;
                    r_hd_y   <= w_ny;
                    r_hd_c   <= w_colour;
                end else begin
                    r_tl_vld <= 1'b1;
                    r_tl_x   <= w_nx;
                    r_tl_y   <= w_ny;
                    r_tl_c   <= w_colour;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_engine.sv
`default_nettype none
//==============================================================================
// Module   : tb_sprite_fetch_engine
// Purpose  : Self-checking bench for sprite_fetch_engine (default parameters);
//            honours TRANSPARENCY_EN when defined.
// Revision : 1.0 - initial release
//==============================================================================
module tb_sprite_fetch_engine;

`ifdef TRANSPARENCY_EN
    localparam bit c_TRANS    = 1'b1;
    localparam int c_ZERO_CNT = 0;
    localparam int c_HALF_CNT = 128;
`else
    localparam bit c_TRANS    = 1'b0;
    localparam int c_ZERO_CNT = 256;
    localparam int c_HALF_CNT = 256;
`endif

    logic        clock, reset, start;
    logic [2:0]  frame_id;
    logic [1:0]  bank_sel;
    logic [7:0]  base_x, base_y;
    logic [10:0] rom_addr;
    logic [11:0] rom_q;
    logic        px_valid, px_ready;
    logic [7:0]  px_x, px_y;
    logic [2:0]  px_colour;
    logic        busy, done;

    sprite_fetch_engine dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .frame_id  (frame_id),
        .bank_sel  (bank_sel),
        .base_x    (base_x),
        .base_y    (base_y),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_colour (px_colour),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed { logic [7:0] x; logic [7:0] y; logic [2:0] c; } px_t;
    typedef struct { int fr; int bk; int bx; int by; int rmode; int count;
                     int fx; int fy; int lx; int ly; int addr; int x7; } vec_t;

    int   n_checks, n_fail, rom_mode;
    px_t  exp_q[$];
    vec_t tbl[5];
    int   g_n_acc, g_first_lat, g_last_acc, g_done_cycle, g_done_cnt, g_first_addr;
    int   g_first_x, g_first_y, g_last_x, g_last_y, g_x7;

    function automatic logic [2:0] rom_colour(input int bank, input int addr);
        logic [2:0] col;
        col = 3'(1 + ((addr * 5 + bank * 3 + addr / 16) % 7));
        if (rom_mode == 1 && bank == 0) col = 3'd0;
        if (rom_mode == 2 && bank == 0 && (addr % 2) == 0) col = 3'd0;
        return col;
    endfunction

    // Sprite ROM: data for an address appears one cycle later.
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            rom_q[b*3 +: 3] <= rom_colour(b, int'(rom_addr));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_blit(input int fr, input int bk, input int bx, input int by,
                            input int rmode, input int restart_at, input int rst_at);
        px_t        exp_px;
        logic [2:0] col;
        logic [18:0] prev;
        bit         stall, rdy, got_done;
        int         c, total;
        exp_q.delete();
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) begin
                col = rom_colour(bk, fr * 256 + j * 16 + i);
                if (!(c_TRANS && col == 3'd0)) begin
                    exp_px.x = 8'((bx + i) % 256);
                    exp_px.y = 8'((by + j) % 256);
                    exp_px.c = col;
                    exp_q.push_back(exp_px);
                end
            end
        end
        total = exp_q.size();
        g_n_acc = 0; g_first_lat = -1; g_last_acc = -1; g_done_cycle = -1; g_done_cnt = 0;
        g_first_addr = -1; g_first_x = -1; g_first_y = -1; g_last_x = -1; g_last_y = -1; g_x7 = -1;
        prev = '0;

        @(negedge clock);
        start = 1'b1; frame_id = 3'(fr); bank_sel = 2'(bk); base_x = 8'(bx); base_y = 8'(by);
        px_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        c = 0; stall = 1'b0; got_done = 1'b0;
        while (!got_done && c < 2000) begin
            if (c == 0) chk("busy_after_start", int'(busy), 1);
            if (c == 1) g_first_addr = int'(rom_addr);
            if (stall) begin
                chk("hold_valid", int'(px_valid), 1);
                chk("hold_pixel", int'({px_x, px_y, px_colour}), int'(prev));
            end
            if (px_valid && g_first_lat < 0) g_first_lat = c;
            if (done) begin
                got_done = 1'b1; g_done_cycle = c; g_done_cnt++;
                chk("busy_low_in_done", int'(busy), 0);
            end
            if (rst_at >= 0 && g_n_acc == rst_at) begin
                reset = 1'b1;
                @(negedge clock);
                chk("abort_valid", int'(px_valid), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_addr", int'(rom_addr), 0);
                reset = 1'b0;
                repeat (10) begin
                    @(negedge clock);
                    chk("abort_no_valid", int'(px_valid), 0);
                    chk("abort_no_done", int'(done), 0);
                end
                exp_q.delete();
                return;
            end
            start = (c == restart_at) && !got_done;
            if (start) begin
                frame_id = 3'd5; bank_sel = 2'd3; base_x = 8'd77; base_y = 8'd66;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((c % 2) == 0) && ($urandom_range(0, 4) != 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            px_ready = rdy;
            if (px_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_overrun", g_n_acc + 1, total);
                end else begin
                    exp_px = exp_q.pop_front();
                    chk("pixel", int'({px_x, px_y, px_colour}), int'(exp_px));
                end
                g_n_acc++;
                g_last_acc = c;
                if (g_n_acc == 1) begin g_first_x = int'(px_x); g_first_y = int'(px_y); end
                if (g_n_acc == 7) g_x7 = int'(px_x);
                g_last_x = int'(px_x); g_last_y = int'(px_y);
            end
            stall = px_valid && !rdy;
            prev = {px_x, px_y, px_colour};
            c++;
            if (!got_done) @(negedge clock);
        end
        start = 1'b0;
        chk("done_seen", int'(got_done), 1);
        chk("pixels_left", exp_q.size(), 0);
        px_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("post_no_valid", int'(px_valid), 0);
            chk("post_no_done", int'(done), 0);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; rom_mode = 0;
        tbl[0] = '{fr:2, bk:1, bx:10,  by:20,  rmode:0, count:256, fx:10,  fy:20,  lx:25,  ly:35,  addr:512,  x7:16};
        tbl[1] = '{fr:0, bk:0, bx:250, by:250, rmode:0, count:256, fx:250, fy:250, lx:9,   ly:9,   addr:0,    x7:0};
        tbl[2] = '{fr:7, bk:3, bx:0,   by:0,   rmode:1, count:256, fx:0,   fy:0,   lx:15,  ly:15,  addr:1792, x7:6};
        tbl[3] = '{fr:5, bk:2, bx:100, by:200, rmode:2, count:256, fx:100, fy:200, lx:115, ly:215, addr:1280, x7:106};
        tbl[4] = '{fr:3, bk:1, bx:255, by:255, rmode:2, count:256, fx:255, fy:255, lx:14,  ly:14,  addr:768,  x7:5};

        reset = 1'b1; start = 1'b0; px_ready = 1'b0;
        frame_id = '0; bank_sel = '0; base_x = '0; base_y = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_px_valid", int'(px_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_px_xy", int'({px_x, px_y}), 0);
        chk("rst_px_colour", int'(px_colour), 0);

        for (int k = 0; k < 5; k++) begin
            run_blit(tbl[k].fr, tbl[k].bk, tbl[k].bx, tbl[k].by, tbl[k].rmode, -1, -1);
            chk("count", g_n_acc, tbl[k].count);
            chk("first_x", g_first_x, tbl[k].fx);
            chk("first_y", g_first_y, tbl[k].fy);
            chk("last_x", g_last_x, tbl[k].lx);
            chk("last_y", g_last_y, tbl[k].ly);
            chk("first_addr", g_first_addr, tbl[k].addr);
            chk("pixel7_x", g_x7, tbl[k].x7);
            chk("first_latency", g_first_lat, 3);
            chk("done_count", g_done_cnt, 1);
            chk("done_after_last", g_done_cycle, g_last_acc + 1);
            if (tbl[k].rmode == 0) chk("throughput_span", g_last_acc - g_first_lat, 255);
        end

        // Second start mid-blit must be ignored.
        run_blit(2, 1, 10, 20, 0, 50, -1);
        chk("restart_count", g_n_acc, 256);
        chk("restart_done", g_done_cnt, 1);
        chk("restart_last_x", g_last_x, 25);

        // Reset after 100 pixels aborts, then a fresh blit runs normally.
        run_blit(2, 1, 10, 20, 0, -1, 100);
        chk("abort_accepts", g_n_acc, 100);
        chk("abort_done_cnt", g_done_cnt, 0);
        run_blit(4, 0, 30, 40, 0, -1, -1);
        chk("after_abort_count", g_n_acc, 256);
        chk("after_abort_latency", g_first_lat, 3);
        chk("after_abort_done", g_done_cnt, 1);

        // Transparent-key patterns in bank 0.
        rom_mode = 1;
        run_blit(2, 0, 10, 20, 0, -1, -1);
        chk("zero_bank_count", g_n_acc, c_ZERO_CNT);
        chk("zero_bank_done", g_done_cnt, 1);
        rom_mode = 2;
        run_blit(2, 0, 10, 20, 2, -1, -1);
        chk("half_bank_count", g_n_acc, c_HALF_CNT);
        chk("half_bank_done", g_done_cnt, 1);
        rom_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_fetch_engine.md
SPRITE_FETCH_ENGINE -- requirements
Module: sprite_fetch_engine

Interface
REQ-001 The block SHALL have parameter SPR_W, default 16, sprite width in pixels (power of 2).
REQ-002 The block SHALL have parameter SPR_H, default 16, sprite height in pixels (power of 2).
REQ-003 The block SHALL have parameter FRAMES, default 8, number of sprite frames per bank (power of 2).
REQ-004 The block SHALL have parameter NUM_BANKS, default 4, number of parallel sprite ROM banks.
REQ-005 The block SHALL have parameter COL_W, default 3, colour width in bits.
REQ-006 The block SHALL have parameter TRANS_COLOUR, default 0, transparent colour key.
REQ-007 clock  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  request to blit one sprite; sampled only in IDLE.
REQ-010 frame_id  in  log2(FRAMES)  frame to draw; latched at accepted start.
REQ-011 bank_sel  in  log2(NUM_BANKS)  ROM bank to draw from; latched at accepted start.
REQ-012 base_x, base_y  in  8 each  screen origin of the sprite; latched at accepted start.
REQ-013 rom_addr  out  log2(FRAMES*SPR_W*SPR_H)  shared read address to all banks.
REQ-014 rom_q  in  NUM_BANKS*COL_W  concatenated bank data; bank b at bits [b*COL_W +: COL_W]; valid exactly one cycle after rom_addr.
REQ-015 px_valid  out  1  pixel on px_* is valid.
REQ-016 px_ready  in  1  downstream accepts the pixel when px_valid and px_ready are both high.
REQ-017 px_x, px_y  out  8 each  pixel screen coordinate.
REQ-018 px_colour  out  COL_W  pixel colour.
REQ-019 busy  out  1  high from the cycle after an accepted start until done.
REQ-020 done  out  1  single-cycle pulse after the last pixel has been accepted.

Function
REQ-021 States SHALL be IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN after the last address issues; DRAIN->DONE when no read is in flight and the buffer is empty; DONE->IDLE unconditionally after one cycle.
REQ-022 start in any state other than IDLE SHALL be ignored, with no effect on latched inputs.
REQ-023 Scan order SHALL be row-major: column i 0..SPR_W-1 inner, row j 0..SPR_H-1 outer.
REQ-024 rom_addr SHALL equal frame_id*SPR_W*SPR_H + j*SPR_W + i (concatenation {frame_id, j, i}); rom_addr SHALL be 0 outside FETCH.
REQ-025 px_x SHALL equal (base_x + i) mod 256 and px_y SHALL equal (base_y + j) mod 256; screen wrap is not clipped.
REQ-026 Output SHALL be buffered in a 2-entry FIFO; a read SHALL issue only when buffered plus in-flight count < 2, so no ROM data is ever dropped under back-pressure.
REQ-027 With px_ready held high, the block SHALL sustain one pixel per cycle; the first px_valid SHALL occur 3 cycles after the start edge.
REQ-028 px_x, px_y and px_colour SHALL hold stable while px_valid is high and px_ready is low.
REQ-029 When the buffer is full and a pixel is popped, a new read SHALL be allowed to issue in the same cycle.
REQ-030 done SHALL assert in the cycle the block enters DONE; busy SHALL be low in IDLE and DONE.

Reset
REQ-031 reset SHALL force: state IDLE; counters, FIFO and in-flight count cleared; px_valid=0; busy=0; done=0; rom_addr=0; px_x=px_y=px_colour=0.
REQ-032 reset during FETCH or DRAIN SHALL abort the blit with no done pulse and no further px_valid.

Configuration
REQ-033 With TRANSPARENCY_EN defined, pixels whose colour equals TRANS_COLOUR SHALL be discarded and not emitted; done SHALL still follow the last emitted pixel, and a fully transparent sprite SHALL produce zero pixels and one done pulse.
REQ-034 Without TRANSPARENCY_EN, all SPR_W*SPR_H pixels SHALL be emitted, and TRANS_COLOUR SHALL be unused.

Verification
REQ-035 Default params, px_ready=1, start with frame 2, bank 1, base (10,20) -> 256 pixels, first at (10,20) rom_addr 512, last at (25,35), done 1 cycle after the last accept.
REQ-036 base (250,250) -> pixel i=6 at x=0, and the final pixel is at (9,9).
REQ-037 px_ready toggles 1010... with random stalls -> no lost or duplicated pixels, outputs stable while stalled, 256 accepts.
REQ-038 start pulsed again mid-blit with frame 5 -> ignored; the run completes with frame 2 data only.
REQ-039 reset asserted at pixel 100 -> next cycle px_valid=0 and busy=0, with no done pulse; a new start then runs normally.
REQ-040 TRANSPARENCY_EN defined, ROM bank 0 all zeros -> zero px_valid, one done pulse; half-zero pattern -> exactly 128 pixels.
